// File: rtl/oam_dma_ctrl_if.sv
// CPU/bus bundle for the OAM DMA sequencer; the slave modport is the controller.
// The DMC fetch signals exist only when OAM_DMA_DMC_EN is defined.
interface oam_dma_ctrl_if;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_halt;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_rw;
  logic [7:0]  dma_wdata;
  logic [7:0]  bus_rdata;
  logic        busy;
`ifdef OAM_DMA_DMC_EN
  logic        dmc_req;
  logic [15:0] dmc_addr;
  logic        dmc_ack;
  logic [7:0]  dmc_data;
`endif

  modport master (
    output cpu_ce, cpu_addr, cpu_wdata, cpu_we, bus_rdata,
`ifdef OAM_DMA_DMC_EN
    output dmc_req, dmc_addr,
    input  dmc_ack, dmc_data,
`endif
    input  cpu_halt, dma_active, dma_addr, dma_rw, dma_wdata, busy
  );

  modport slave (
    input  cpu_ce, cpu_addr, cpu_wdata, cpu_we, bus_rdata,
`ifdef OAM_DMA_DMC_EN
    input  dmc_req, dmc_addr,
    output dmc_ack, dmc_data,
`endif
    output cpu_halt, dma_active, dma_addr, dma_rw, dma_wdata, busy
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA bus sequencer: halts the CPU and copies one page to OAMDATA in get/put pairs.
// Define OAM_DMA_DMC_EN to add DMC sample fetches that steal get cycles.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [15:0] OAMDATA_ADDR = 16'h2004,
  parameter int          XFER_LEN     = 256
) (
  input logic           clk,
  input logic           reset,
  oam_dma_ctrl_if.slave bus
);
  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
`ifdef OAM_DMA_DMC_EN
    , DMC_RD
`endif
  } state_e;

  state_e     state_q, state_d, nextGet;
  logic       parity_q;
  logic [7:0] idx_q, idx_d;
  logic [7:0] page_q, page_d;
  logic [7:0] latch_q, latch_d;
  logic       trigger;
`ifdef OAM_DMA_DMC_EN
  logic       oam_q, oam_d;
  logic       dmcPend_q, dmcPend_d;
  logic [7:0] dmcData_q, dmcData_d;
`endif

  assign trigger = bus.cpu_we && (bus.cpu_addr == DMA_REG_ADDR);

  // State register: reset acts on any clk, everything else only on CPU cycle ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      parity_q  <= 1'b0;
      idx_q     <= 8'h00;
      page_q    <= 8'h00;
      latch_q   <= 8'h00;
`ifdef OAM_DMA_DMC_EN
      oam_q     <= 1'b0;
      dmcPend_q <= 1'b0;
      dmcData_q <= 8'h00;
`endif
    end else if (bus.cpu_ce) begin
      state_q   <= state_d;
      parity_q  <= ~parity_q;
      idx_q     <= idx_d;
      page_q    <= page_d;
      latch_q   <= latch_d;
`ifdef OAM_DMA_DMC_EN
      oam_q     <= oam_d;
      dmcPend_q <= dmcPend_d;
      dmcData_q <= dmcData_d;
`endif
    end
  end

  // Next-state logic; nextGet picks who owns the upcoming get cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    page_d  = page_q;
    latch_d = latch_q;
`ifdef OAM_DMA_DMC_EN
    oam_d     = oam_q;
    dmcPend_d = dmcPend_q | bus.dmc_req;
    dmcData_d = dmcData_q;
    nextGet   = (dmcPend_q || bus.dmc_req) ? DMC_RD : READ;
`else
    nextGet   = READ;
`endif
    case (state_q)
      IDLE: begin
        if (trigger) begin
          page_d  = bus.cpu_wdata;
          idx_d   = 8'h00;
          state_d = HALT;
`ifdef OAM_DMA_DMC_EN
          oam_d   = 1'b1;
        end else if (bus.dmc_req) begin
          oam_d   = 1'b0;
          state_d = HALT;
`endif
        end
      end
      HALT:  state_d = parity_q ? nextGet : ALIGN;
      ALIGN: state_d = nextGet;
      READ: begin
        latch_d = bus.bus_rdata;
        state_d = WRITE;
      end
      WRITE: begin
        idx_d   = idx_q + 8'h01;
        state_d = (idx_q == LAST_IDX) ? IDLE : nextGet;
      end
`ifdef OAM_DMA_DMC_EN
      DMC_RD: begin
        dmcData_d = bus.bus_rdata;
        dmcPend_d = 1'b0;
        state_d   = oam_q ? ALIGN : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded purely from registered state.
  always_comb begin
    bus.cpu_halt   = (state_q != IDLE);
    bus.busy       = (state_q != IDLE);
    bus.dma_active = 1'b0;
    bus.dma_rw     = 1'b0;
    bus.dma_addr   = 16'h0000;
    bus.dma_wdata  = 8'h00;
`ifdef OAM_DMA_DMC_EN
    bus.dmc_ack    = 1'b0;
    bus.dmc_data   = dmcData_q;
`endif
    case (state_q)
      READ: begin
        bus.dma_active = 1'b1;
        bus.dma_rw     = 1'b1;
        bus.dma_addr   = {page_q, idx_q};
      end
      WRITE: begin
        bus.dma_active = 1'b1;
        bus.dma_addr   = OAMDATA_ADDR;
        bus.dma_wdata  = latch_q;
      end
`ifdef OAM_DMA_DMC_EN
      DMC_RD: begin
        bus.dma_active = 1'b1;
        bus.dma_rw     = 1'b1;
        bus.dma_addr   = bus.dmc_addr;
        bus.dmc_ack    = bus.cpu_ce;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized directed bench for oam_dma_ctrl against a per-cycle bus schedule model.
// Each CPU cycle is two clks with cpu_ce on the second; outputs are sampled 1 time unit after edges.
module tb_oam_dma_ctrl;
  logic clk;
  logic reset;
  logic [7:0] mem [65536];
  int assertCount;
  int failCount;
  int cycleCount;

  oam_dma_ctrl_if ifc ();

  oam_dma_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  assign ifc.bus_rdata = mem[ifc.dma_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef OAM_DMA_DMC_EN
  initial begin
    ifc.dmc_req  = 1'b0;
    ifc.dmc_addr = 16'h0000;
  end
`endif

  function automatic logic [31:0] observed();
    return {4'h0, ifc.cpu_halt, ifc.busy, ifc.dma_active, ifc.dma_rw, ifc.dma_addr, ifc.dma_wdata};
  endfunction

  // Expected bus for CPU cycle k after the trigger: gap halted cycles, then 256 read/write pairs.
  function automatic logic [31:0] modelBus(input int k, input int gap, input logic [7:0] page);
    int j;
    logic [7:0] i;
    if (k < gap) return {4'h0, 4'b1100, 24'h0};
    j = k - gap;
    if (j >= 512) return 32'h0;
    i = 8'(j / 2);
    if (j % 2 == 0) return {4'h0, 4'b1111, page, i, 8'h00};
    return {4'h0, 4'b1110, 16'h2004, mem[{page, i}]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [7:0] wd);
    ifc.cpu_we    = we;
    ifc.cpu_addr  = addr;
    ifc.cpu_wdata = wd;
    ifc.cpu_ce    = 1'b0;
    @(posedge clk);
    #1;
    ifc.cpu_ce = 1'b1;
    @(posedge clk);
    #1;
    ifc.cpu_ce = 1'b0;
    cycleCount++;
  endtask

  task automatic applyReset(input int clks);
    ifc.cpu_ce = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("resetOutputs", observed(), 32'h0);
    repeat (clks - 1) @(posedge clk);
    #1;
    reset      = 1'b0;
    cycleCount = 0;
  endtask

  task automatic idleNoise(input int n);
    logic [15:0] a;
    for (int c = 0; c < n; c++) begin
      a = 16'($urandom);
      if (a == 16'h4014) a = 16'h4015;
      applyStimulus(1'($urandom_range(0, 1)), a, 8'($urandom));
      checkOutput("idleBus", observed(), 32'h0);
    end
  endtask

  // One DMA: trigger, then check every CPU cycle against the schedule model.
  task automatic runTransfer(input logic [7:0] page, input bit finalTrigger, input int abortAfter);
    int gap;
    int last;
    int halted;
    int writes;
    logic [15:0] a;
    applyStimulus(1'b1, 16'h4014, page);
    gap    = (cycleCount % 2 == 0) ? 2 : 1;
    last   = gap + 512;
    halted = 0;
    writes = 0;
    for (int k = 0; k <= last + 1; k++) begin
      if (abortAfter >= 0 && k == gap + 2 * abortAfter) begin
        checkOutput("preAbort", observed(), modelBus(k, gap, page));
        applyReset(3);
        return;
      end
      checkOutput("busCycle", observed(), modelBus(k, gap, page));
      if (ifc.cpu_halt === 1'b1) halted++;
      if (ifc.dma_active === 1'b1 && ifc.dma_rw === 1'b0 && ifc.dma_addr === 16'h2004) writes++;
      if (k <= last) begin
        if (finalTrigger && k == last - 1) begin
          applyStimulus(1'b1, 16'h4014, ~page);
        end else begin
          a = 16'($urandom);
          if (a == 16'h4014) a = 16'h4015;
          applyStimulus(1'($urandom_range(0, 1)), a, 8'($urandom));
        end
      end
    end
    checkOutput("haltLength", halted, (gap == 1) ? 513 : 514);
    checkOutput("writeCount", writes, 256);
  endtask

  initial begin
    assertCount   = 0;
    failCount     = 0;
    cycleCount    = 0;
    reset         = 1'b1;
    ifc.cpu_ce    = 1'b0;
    ifc.cpu_we    = 1'b0;
    ifc.cpu_addr  = 16'h0000;
    ifc.cpu_wdata = 8'h00;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

    applyReset(3);
    idleNoise(5);

    // HALT on a put cycle (513), then HALT on a get cycle with ALIGN (514).
    if (cycleCount % 2 != 0) idleNoise(1);
    runTransfer(8'h02, 1'b0, -1);
    if (cycleCount % 2 == 0) idleNoise(1);
    runTransfer(8'h02, 1'b0, -1);

    // Top page wraps inside the page; a trigger on the final write is ignored.
    runTransfer(8'hFF, 1'b1, -1);
    idleNoise($urandom_range(0, 3));
    runTransfer(8'($urandom_range(0, 255)), 1'b1, -1);

    // Reset after the 10th write, then a fresh transfer starts at idx 0.
    runTransfer(8'($urandom_range(0, 255)), 1'b0, 10);
    idleNoise(2);
    runTransfer(8'h02, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
